fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset, bits [1:0] SHALL be zero.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, legal values 2..8.
REQ-003 clock  in  1: single clock, all state on rising edge.
REQ-004 reset  in  1: synchronous, active-high.
REQ-005 mem_req  out  1: fetch request to instruction memory.
REQ-006 mem_addr  out  32: word-aligned fetch address, held stable while mem_req=1 and mem_ack=0.
REQ-007 mem_ack  in  1: request accepted; mem_data valid in the same cycle.
REQ-008 mem_data  in  32: fetched instruction word.
REQ-009 instruction  out  32: head-of-buffer instruction to the core decoder.
REQ-010 instr_pc  out  32: address of instruction.
REQ-011 instr_valid  out  1: instruction/instr_pc valid.
REQ-012 instr_ready  in  1: core consumes the head entry when instr_valid=1 and instr_ready=1.
REQ-013 redirect  in  1: branch/jump taken; discard all buffered and in-flight fetches.
REQ-014 redirect_pc  in  32: new fetch address; bits [1:0] ignored and forced to zero.

Function
REQ-015 The block SHALL implement three states: IDLE (no request outstanding), REQ (mem_req=1 awaiting mem_ack) and FLUSH (mem_req=1, response to be discarded).
REQ-016 IDLE->REQ when buffer occupancy < DEPTH; REQ stays until mem_ack.
REQ-017 On mem_ack in REQ, the block SHALL write {mem_addr, mem_data} into the buffer, advance fetch pc by 4 and remain in REQ with the next address if occupancy after this cycle's push/pop is < DEPTH, else go to IDLE.
REQ-018 With mem_ack tied high and instr_ready tied high, throughput SHALL be one instruction per cycle after the first.
REQ-019 Latency: mem_ack in cycle N SHALL make that entry visible on instruction with instr_valid=1 in cycle N+1 when the buffer was empty.
REQ-020 The buffer SHALL be FIFO-ordered; push and pop in the same cycle when full SHALL be legal and SHALL preserve occupancy.
REQ-021 instruction, instr_pc and instr_valid SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-022 Fetch pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-023 Redirect in IDLE or REQ-with-mem_ack: the buffer SHALL be flushed, pc loaded with redirect_pc, state REQ next cycle with mem_addr=redirect_pc, and the acked data discarded.
REQ-024 Redirect in REQ without mem_ack: state->FLUSH, mem_req and mem_addr held until mem_ack, that data discarded, then REQ at redirect_pc.
REQ-025 Redirect in FLUSH SHALL replace the pending target pc; only the newest redirect_pc is fetched.
REQ-026 A consume handshake coinciding with redirect SHALL count as consumed; instr_valid SHALL be 0 in the following cycle.

Reset
REQ-027 While reset=1: mem_req=0, instr_valid=0, buffer empty, state IDLE, pc=RESET_PC; instruction/instr_pc/mem_addr SHALL read 0 except mem_addr=RESET_PC.
REQ-028 Reset asserted mid-transaction SHALL abandon the outstanding request; a mem_ack during reset SHALL be ignored.
REQ-029 First cycle after reset deasserts, mem_req SHALL be 1 with mem_addr=RESET_PC.

Configuration
REQ-030 With FETCH_PERF_EN defined, outputs perf_fetched (32 bits, count of buffer pushes) and perf_stall (32 bits, cycles with instr_ready=1 and instr_valid=0) SHALL exist, cleared by reset, wrapping on overflow.
REQ-031 Without FETCH_PERF_EN, these ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (IDLE, REQ, FLUSH), XLEN=32, INSTR_ALIGN=4 and the buffer-entry struct {pc, instr}.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (synchronous, DEPTH-parameterised, flush input, push/pop/full/empty/count).

Verification
REQ-034 Reset release, mem_ack=1, instr_ready=1 -> mem_addr 0,4,8,... on consecutive cycles; instr_pc 0,4,8 from cycle after first ack.
REQ-035 instr_ready=0 for 5 cycles, DEPTH=2 -> exactly two pushes (pc 0,4), mem_req=0 afterwards, instruction held at pc 0.
REQ-036 mem_ack delayed 3 cycles for addr 8 -> mem_addr=8 stable for all 3 cycles, no extra push.
REQ-037 redirect to 32'h100 while addr 8 outstanding -> FLUSH, data for 8 dropped, next mem_addr=32'h100, first instr_pc=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 reset asserted while mem_req=1 and mem_ack=1 -> no push, instr_valid=0, mem_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM state encoding, buffer entry layout and PC alignment helper.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_ALIGN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INSTR_ALIGN - 1));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       pop_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential fetch into a small buffer, redirect/flush handling.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_data,
    output logic [XLEN-1:0]  instruction,
    output logic [XLEN-1:0]  instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output fetch_state_e     dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    target_q, target_d;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   occ_pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = mem_data;

    // Consume handshake: valid/ready both high in a cycle pops the head entry,
    // even if a redirect flushes the buffer in that same cycle.
    assign instr_valid = !reset && !fifo_empty;
    assign fifo_pop    = instr_valid && instr_ready;
    assign occ_pop     = fifo_count - CNT_W'(fifo_pop);

    assign mem_req     = !reset && (state_q != IDLE);
    assign mem_addr    = reset ? RESET_PC : pc_q;
    assign instruction = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign dbg_state   = reset ? IDLE : state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fifo_flush = 1'b1;
                    pc_d       = align_pc(redirect_pc);
                    state_d    = REQ;
                end else if (!fifo_full || fifo_pop) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        fifo_flush = 1'b1;
                        pc_d       = align_pc(redirect_pc);
                    end else begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + XLEN'(INSTR_ALIGN);
                        // Keep streaming only if the buffer still has room after this push.
                        state_d   = (occ_pop < CNT_W'(DEPTH - 1)) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    fifo_flush = 1'b1;
                    target_d   = align_pc(redirect_pc);
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                fifo_flush = redirect;
                if (mem_ack) begin
                    pc_d    = redirect ? align_pc(redirect_pc) : target_q;
                    state_d = REQ;
                end else if (redirect) begin
                    target_d = align_pc(redirect_pc);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(fifo_push);
        perf_stall_d   = perf_stall_q + 32'(instr_ready && !instr_valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, streaming, backpressure,
// delayed ack, redirects, PC wrap (second instance with a high RESET_PC).
module tb_fetch_unit;
    import fetch_pkg::*;

    logic         clock;
    logic         reset;
    logic         mem_ack;
    logic         instr_ready;
    logic         redirect;
    logic [31:0]  redirect_pc;

    logic         mem_req, mem_req_hi;
    logic [31:0]  mem_addr, mem_addr_hi;
    logic [31:0]  mem_data, mem_data_hi;
    logic [31:0]  instruction, instruction_hi;
    logic [31:0]  instr_pc, instr_pc_hi;
    logic         instr_valid, instr_valid_hi;
    fetch_state_e dbg_state, dbg_state_hi;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_fetched, perf_stall, perf_fetched_hi, perf_stall_hi;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_data    = mem_word(mem_addr);
    assign mem_data_hi = mem_word(mem_addr_hi);

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dbg_state   (dbg_state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_hi (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req_hi),
        .mem_addr    (mem_addr_hi),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data_hi),
        .instruction (instruction_hi),
        .instr_pc    (instr_pc_hi),
        .instr_valid (instr_valid_hi),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dbg_state   (dbg_state_hi)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched_hi),
        .perf_stall   (perf_stall_hi)
`endif
    );

    // Clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        tick();
        tick();
        check("rst_mem_req",     32'(mem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_mem_addr",    mem_addr, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_instr_pc",    instr_pc, 32'h0);
        check("rst_state",       32'(dbg_state), 32'(IDLE));
        check("rst_hi_mem_addr", mem_addr_hi, 32'hFFFF_FFF8);
        reset = 1'b0;

        // Streaming with ack/ready high, plus PC wrap on the high instance
        tick();
        for (int k = 0; k < 4; k++) begin
            check("seq_mem_req",  32'(mem_req), 32'd1);
            check("seq_mem_addr", mem_addr, 32'(4 * k));
            check("seq_valid",    32'(instr_valid), 32'(k > 0));
            check("hi_mem_addr",  mem_addr_hi, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k > 0) begin
                check("seq_instr_pc",    instr_pc, 32'(4 * (k - 1)));
                check("seq_instruction", instruction, mem_word(32'(4 * (k - 1))));
                check("hi_instr_pc",     instr_pc_hi, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
            end
            if (k < 3) tick();
        end

        // Reset while a request is being acked
        reset = 1'b1;
        #1;
        check("midrst_mem_req",  32'(mem_req), 32'd0);
        check("midrst_valid",    32'(instr_valid), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        tick();
        check("midrst2_mem_req", 32'(mem_req), 32'd0);
        check("midrst2_valid",   32'(instr_valid), 32'd0);
        check("midrst2_state",   32'(dbg_state), 32'(IDLE));
        reset       = 1'b0;
        instr_ready = 1'b0;

        // Backpressure fills the two-entry buffer then stops requesting
        tick();
        check("post_rst_mem_req",  32'(mem_req), 32'd1);
        check("post_rst_mem_addr", mem_addr, 32'h0);
        check("post_rst_valid",    32'(instr_valid), 32'd0);
        tick();
        check("bp_mem_addr", mem_addr, 32'h4);
        check("bp_instr_pc", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_mem_req", 32'(mem_req), 32'd0);
            check("bp_hold_valid",   32'(instr_valid), 32'd1);
            check("bp_hold_pc",      instr_pc, 32'h0);
            check("bp_hold_instr",   instruction, mem_word(32'h0));
            check("bp_hold_state",   32'(dbg_state), 32'(IDLE));
        end

        // Delayed ack on address 8
        instr_ready = 1'b1;
        mem_ack     = 1'b0;
        tick();
        check("dly_instr_pc", instr_pc, 32'h4);
        check("dly_mem_req",  32'(mem_req), 32'd1);
        check("dly_mem_addr", mem_addr, 32'h8);
        instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("dly_hold_addr", mem_addr, 32'h8);
            check("dly_hold_req",  32'(mem_req), 32'd1);
            check("dly_hold_pc",   instr_pc, 32'h4);
        end
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("dly_done_pc",    instr_pc, 32'h8);
        check("dly_done_instr", instruction, mem_word(32'h8));
        check("dly_done_addr",  mem_addr, 32'hC);

        // Redirect while a request is outstanding without ack
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check("fl_state",   32'(dbg_state), 32'(FLUSH));
        check("fl_mem_req", 32'(mem_req), 32'd1);
        check("fl_addr",    mem_addr, 32'hC);
        check("fl_valid",   32'(instr_valid), 32'd0);
        redirect = 1'b0;
        tick();
        check("fl_hold_state", 32'(dbg_state), 32'(FLUSH));
        check("fl_hold_addr",  mem_addr, 32'hC);
        mem_ack = 1'b1;
        tick();
        check("fl_done_state", 32'(dbg_state), 32'(REQ));
        check("fl_done_addr",  mem_addr, 32'h100);
        check("fl_done_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        tick();
        check("fl_first_valid", 32'(instr_valid), 32'd1);
        check("fl_first_pc",    instr_pc, 32'h100);
        check("fl_first_instr", instruction, mem_word(32'h100));
        check("fl_next_addr",   mem_addr, 32'h104);

        // Redirect coinciding with ack and a consume
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("rda_valid", 32'(instr_valid), 32'd0);
        check("rda_addr",  mem_addr, 32'h40);
        check("rda_state", 32'(dbg_state), 32'(REQ));
        redirect = 1'b0;
        tick();
        check("rda_pc",   instr_pc, 32'h40);
        check("rda_next", mem_addr, 32'h44);

        // Two redirects during FLUSH: only the newest (low bits dropped) is fetched
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        check("rr_state", 32'(dbg_state), 32'(FLUSH));
        check("rr_addr",  mem_addr, 32'h44);
        check("rr_valid", 32'(instr_valid), 32'd0);
        redirect_pc = 32'hC3;
        tick();
        check("rr2_state", 32'(dbg_state), 32'(FLUSH));
        check("rr2_addr",  mem_addr, 32'h44);
        redirect = 1'b0;
        mem_ack  = 1'b1;
        tick();
        check("rr_done_state", 32'(dbg_state), 32'(REQ));
        check("rr_done_addr",  mem_addr, 32'hC0);
        check("rr_done_valid", 32'(instr_valid), 32'd0);
        tick();
        check("rr_first_pc",    instr_pc, 32'hC0);
        check("rr_first_instr", instruction, mem_word(32'hC0));
        check("rr_next_addr",   mem_addr, 32'hC4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
